// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule types and helpers: word type, schedule FSM
// states, round constants and RotWord.
package aes_key_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round 0 has no Rcon; any out-of-table round yields zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a 256-entry lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  always_comb begin
    s_o = 8'h00;
    case (a_i)
      8'h00: s_o = 8'h63; 8'h01: s_o = 8'h7c; 8'h02: s_o = 8'h77; 8'h03: s_o = 8'h7b; 8'h04: s_o = 8'hf2; 8'h05: s_o = 8'h6b; 8'h06: s_o = 8'h6f; 8'h07: s_o = 8'hc5;
      8'h08: s_o = 8'h30; 8'h09: s_o = 8'h01; 8'h0a: s_o = 8'h67; 8'h0b: s_o = 8'h2b; 8'h0c: s_o = 8'hfe; 8'h0d: s_o = 8'hd7; 8'h0e: s_o = 8'hab; 8'h0f: s_o = 8'h76;
      8'h10: s_o = 8'hca; 8'h11: s_o = 8'h82; 8'h12: s_o = 8'hc9; 8'h13: s_o = 8'h7d; 8'h14: s_o = 8'hfa; 8'h15: s_o = 8'h59; 8'h16: s_o = 8'h47; 8'h17: s_o = 8'hf0;
      8'h18: s_o = 8'had; 8'h19: s_o = 8'hd4; 8'h1a: s_o = 8'ha2; 8'h1b: s_o = 8'haf; 8'h1c: s_o = 8'h9c; 8'h1d: s_o = 8'ha4; 8'h1e: s_o = 8'h72; 8'h1f: s_o = 8'hc0;
      8'h20: s_o = 8'hb7; 8'h21: s_o = 8'hfd; 8'h22: s_o = 8'h93; 8'h23: s_o = 8'h26; 8'h24: s_o = 8'h36; 8'h25: s_o = 8'h3f; 8'h26: s_o = 8'hf7; 8'h27: s_o = 8'hcc;
      8'h28: s_o = 8'h34; 8'h29: s_o = 8'ha5; 8'h2a: s_o = 8'he5; 8'h2b: s_o = 8'hf1; 8'h2c: s_o = 8'h71; 8'h2d: s_o = 8'hd8; 8'h2e: s_o = 8'h31; 8'h2f: s_o = 8'h15;
      8'h30: s_o = 8'h04; 8'h31: s_o = 8'hc7; 8'h32: s_o = 8'h23; 8'h33: s_o = 8'hc3; 8'h34: s_o = 8'h18; 8'h35: s_o = 8'h96; 8'h36: s_o = 8'h05; 8'h37: s_o = 8'h9a;
      8'h38: s_o = 8'h07; 8'h39: s_o = 8'h12; 8'h3a: s_o = 8'h80; 8'h3b: s_o = 8'he2; 8'h3c: s_o = 8'heb; 8'h3d: s_o = 8'h27; 8'h3e: s_o = 8'hb2; 8'h3f: s_o = 8'h75;
      8'h40: s_o = 8'h09; 8'h41: s_o = 8'h83; 8'h42: s_o = 8'h2c; 8'h43: s_o = 8'h1a; 8'h44: s_o = 8'h1b; 8'h45: s_o = 8'h6e; 8'h46: s_o = 8'h5a; 8'h47: s_o = 8'ha0;
      8'h48: s_o = 8'h52; 8'h49: s_o = 8'h3b; 8'h4a: s_o = 8'hd6; 8'h4b: s_o = 8'hb3; 8'h4c: s_o = 8'h29; 8'h4d: s_o = 8'he3; 8'h4e: s_o = 8'h2f; 8'h4f: s_o = 8'h84;
      8'h50: s_o = 8'h53; 8'h51: s_o = 8'hd1; 8'h52: s_o = 8'h00; 8'h53: s_o = 8'hed; 8'h54: s_o = 8'h20; 8'h55: s_o = 8'hfc; 8'h56: s_o = 8'hb1; 8'h57: s_o = 8'h5b;
      8'h58: s_o = 8'h6a; 8'h59: s_o = 8'hcb; 8'h5a: s_o = 8'hbe; 8'h5b: s_o = 8'h39; 8'h5c: s_o = 8'h4a; 8'h5d: s_o = 8'h4c; 8'h5e: s_o = 8'h58; 8'h5f: s_o = 8'hcf;
      8'h60: s_o = 8'hd0; 8'h61: s_o = 8'hef; 8'h62: s_o = 8'haa; 8'h63: s_o = 8'hfb; 8'h64: s_o = 8'h43; 8'h65: s_o = 8'h4d; 8'h66: s_o = 8'h33; 8'h67: s_o = 8'h85;
      8'h68: s_o = 8'h45; 8'h69: s_o = 8'hf9; 8'h6a: s_o = 8'h02; 8'h6b: s_o = 8'h7f; 8'h6c: s_o = 8'h50; 8'h6d: s_o = 8'h3c; 8'h6e: s_o = 8'h9f; 8'h6f: s_o = 8'ha8;
      8'h70: s_o = 8'h51; 8'h71: s_o = 8'ha3; 8'h72: s_o = 8'h40; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'h92; 8'h75: s_o = 8'h9d; 8'h76: s_o = 8'h38; 8'h77: s_o = 8'hf5;
      8'h78: s_o = 8'hbc; 8'h79: s_o = 8'hb6; 8'h7a: s_o = 8'hda; 8'h7b: s_o = 8'h21; 8'h7c: s_o = 8'h10; 8'h7d: s_o = 8'hff; 8'h7e: s_o = 8'hf3; 8'h7f: s_o = 8'hd2;
      8'h80: s_o = 8'hcd; 8'h81: s_o = 8'h0c; 8'h82: s_o = 8'h13; 8'h83: s_o = 8'hec; 8'h84: s_o = 8'h5f; 8'h85: s_o = 8'h97; 8'h86: s_o = 8'h44; 8'h87: s_o = 8'h17;
      8'h88: s_o = 8'hc4; 8'h89: s_o = 8'ha7; 8'h8a: s_o = 8'h7e; 8'h8b: s_o = 8'h3d; 8'h8c: s_o = 8'h64; 8'h8d: s_o = 8'h5d; 8'h8e: s_o = 8'h19; 8'h8f: s_o = 8'h73;
      8'h90: s_o = 8'h60; 8'h91: s_o = 8'h81; 8'h92: s_o = 8'h4f; 8'h93: s_o = 8'hdc; 8'h94: s_o = 8'h22; 8'h95: s_o = 8'h2a; 8'h96: s_o = 8'h90; 8'h97: s_o = 8'h88;
      8'h98: s_o = 8'h46; 8'h99: s_o = 8'hee; 8'h9a: s_o = 8'hb8; 8'h9b: s_o = 8'h14; 8'h9c: s_o = 8'hde; 8'h9d: s_o = 8'h5e; 8'h9e: s_o = 8'h0b; 8'h9f: s_o = 8'hdb;
      8'ha0: s_o = 8'he0; 8'ha1: s_o = 8'h32; 8'ha2: s_o = 8'h3a; 8'ha3: s_o = 8'h0a; 8'ha4: s_o = 8'h49; 8'ha5: s_o = 8'h06; 8'ha6: s_o = 8'h24; 8'ha7: s_o = 8'h5c;
      8'ha8: s_o = 8'hc2; 8'ha9: s_o = 8'hd3; 8'haa: s_o = 8'hac; 8'hab: s_o = 8'h62; 8'hac: s_o = 8'h91; 8'had: s_o = 8'h95; 8'hae: s_o = 8'he4; 8'haf: s_o = 8'h79;
      8'hb0: s_o = 8'he7; 8'hb1: s_o = 8'hc8; 8'hb2: s_o = 8'h37; 8'hb3: s_o = 8'h6d; 8'hb4: s_o = 8'h8d; 8'hb5: s_o = 8'hd5; 8'hb6: s_o = 8'h4e; 8'hb7: s_o = 8'ha9;
      8'hb8: s_o = 8'h6c; 8'hb9: s_o = 8'h56; 8'hba: s_o = 8'hf4; 8'hbb: s_o = 8'hea; 8'hbc: s_o = 8'h65; 8'hbd: s_o = 8'h7a; 8'hbe: s_o = 8'hae; 8'hbf: s_o = 8'h08;
      8'hc0: s_o = 8'hba; 8'hc1: s_o = 8'h78; 8'hc2: s_o = 8'h25; 8'hc3: s_o = 8'h2e; 8'hc4: s_o = 8'h1c; 8'hc5: s_o = 8'ha6; 8'hc6: s_o = 8'hb4; 8'hc7: s_o = 8'hc6;
      8'hc8: s_o = 8'he8; 8'hc9: s_o = 8'hdd; 8'hca: s_o = 8'h74; 8'hcb: s_o = 8'h1f; 8'hcc: s_o = 8'h4b; 8'hcd: s_o = 8'hbd; 8'hce: s_o = 8'h8b; 8'hcf: s_o = 8'h8a;
      8'hd0: s_o = 8'h70; 8'hd1: s_o = 8'h3e; 8'hd2: s_o = 8'hb5; 8'hd3: s_o = 8'h66; 8'hd4: s_o = 8'h48; 8'hd5: s_o = 8'h03; 8'hd6: s_o = 8'hf6; 8'hd7: s_o = 8'h0e;
      8'hd8: s_o = 8'h61; 8'hd9: s_o = 8'h35; 8'hda: s_o = 8'h57; 8'hdb: s_o = 8'hb9; 8'hdc: s_o = 8'h86; 8'hdd: s_o = 8'hc1; 8'hde: s_o = 8'h1d; 8'hdf: s_o = 8'h9e;
      8'he0: s_o = 8'he1; 8'he1: s_o = 8'hf8; 8'he2: s_o = 8'h98; 8'he3: s_o = 8'h11; 8'he4: s_o = 8'h69; 8'he5: s_o = 8'hd9; 8'he6: s_o = 8'h8e; 8'he7: s_o = 8'h94;
      8'he8: s_o = 8'h9b; 8'he9: s_o = 8'h1e; 8'hea: s_o = 8'h87; 8'heb: s_o = 8'he9; 8'hec: s_o = 8'hce; 8'hed: s_o = 8'h55; 8'hee: s_o = 8'h28; 8'hef: s_o = 8'hdf;
      8'hf0: s_o = 8'h8c; 8'hf1: s_o = 8'ha1; 8'hf2: s_o = 8'h89; 8'hf3: s_o = 8'h0d; 8'hf4: s_o = 8'hbf; 8'hf5: s_o = 8'he6; 8'hf6: s_o = 8'h42; 8'hf7: s_o = 8'h68;
      8'hf8: s_o = 8'h41; 8'hf9: s_o = 8'h99; 8'hfa: s_o = 8'h2d; 8'hfb: s_o = 8'h0f; 8'hfc: s_o = 8'hb0; 8'hfd: s_o = 8'h54; 8'hfe: s_o = 8'hbb; 8'hff: s_o = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative inverse AES-128 key schedule: starts from the round-10 key and
// walks back to round 0, emitting each round key over a valid/ready port.
module aes_inv_key_sched
  import aes_key_pkg::*;
#(
  parameter int BYTE_SERIAL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] key_out,
  output logic [3:0]   RD,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  // Handshake: a key transfers on any rising edge where key_valid and
  // key_ready are both high; while key_valid is high and key_ready low,
  // key_out and RD hold. key_ready with key_valid low has no effect.

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rd_q, rd_d;
  logic         done_q, done_d;

  word_t c0, c1, c2, c3;
  word_t p0, p1, p2, p3;
  word_t rw, t;
  logic  step_last;

  assign c0 = key_q[127:96];
  assign c1 = key_q[95:64];
  assign c2 = key_q[63:32];
  assign c3 = key_q[31:0];

  // Undo w[i] = w[i-1] ^ w[i-4] for the three plain words, then the
  // SubWord/RotWord/Rcon word using the already-recovered previous w3.
  assign p3 = c3 ^ c2;
  assign p2 = c2 ^ c1;
  assign p1 = c1 ^ c0;
  assign rw = rot_word(p3);
  assign p0 = c0 ^ t ^ {rcon_of(rd_q), 24'h000000};

  if (BYTE_SERIAL != 0) begin : g_serial
    logic [1:0]  cnt_q;
    logic [23:0] t_q;
    logic [7:0]  sb_in, sb_out;

    always_comb begin
      sb_in = rw[31:24];
      case (cnt_q)
        2'd1:    sb_in = rw[23:16];
        2'd2:    sb_in = rw[15:8];
        2'd3:    sb_in = rw[7:0];
        default: sb_in = rw[31:24];
      endcase
    end

    aes_sbox u_sbox (.a_i(sb_in), .s_o(sb_out));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 2'd0;
        t_q   <= 24'h000000;
      end else if (state_q == SUB) begin
        cnt_q <= cnt_q + 2'd1;
        t_q   <= {t_q[15:0], sb_out};
      end else begin
        cnt_q <= 2'd0;
      end
    end

    // Byte 3 is consumed live from the S-box on the final count.
    assign t         = {t_q, sb_out};
    assign step_last = (cnt_q == 2'd3);
  end else begin : g_parallel
    for (genvar i = 0; i < 4; i++) begin : g_sb
      aes_sbox u_sbox (.a_i(rw[31-8*i -: 8]), .s_o(t[31-8*i -: 8]));
    end
    assign step_last = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          rd_d    = 4'd10;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (rd_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (step_last) begin
          key_d   = {p0, p1, p2, p3};
          rd_d    = rd_q - 4'd1;
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rd_q    <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = key_q;
  assign RD        = rd_q;
  assign key_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched, exercising the byte-serial and
// the four-S-box builds one after the other with FIPS-197 and all-zero keys.
module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst_n;
  logic [1:0]   start_v;
  logic [127:0] last_key;
  logic         key_ready;

  logic [127:0] key_out_w [2];
  logic [3:0]   rd_w      [2];
  logic         kv_w      [2];
  logic         busy_w    [2];
  logic         done_w    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_inv_key_sched #(.BYTE_SERIAL((g == 0) ? 1 : 0)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[g]),
      .last_key (last_key),
      .key_out  (key_out_w[g]),
      .RD       (rd_w[g]),
      .key_valid(kv_w[g]),
      .key_ready(key_ready),
      .busy     (busy_w[g]),
      .done     (done_w[g])
    );
  end

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference tables (FIPS-197 expansions) ----------------
  logic [127:0] fips_k [0:10];
  logic [127:0] zero_k [0:10];

  // ---------------- scoreboard ----------------
  logic [131:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;
  int lat      = 5;
  int full     = 51;
  int start_cyc = 0;

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (dut %0d): got %h required %h", name, sel, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (dut %0d): bound expired or unexpected event", name, sel);
  endtask

  // ---------------- monitor ----------------
  logic         gap_pending = 1'b0;
  logic         stall_pending = 1'b0;
  int           hs_cyc = 0;
  logic [131:0] held;
  logic [131:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      gap_pending   = 1'b0;
      stall_pending = 1'b0;
    end else if (kv_w[sel]) begin
      if (gap_pending) begin
        check("step_latency", 132'(cyc - hs_cyc), 132'(lat));
        gap_pending = 1'b0;
      end
      if (stall_pending) check("stall_hold", {rd_w[sel], key_out_w[sel]}, held);
      if (key_ready) begin
        stall_pending = 1'b0;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_key");
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("key_rd%0d", mon_e[131:128]), {rd_w[sel], key_out_w[sel]}, mon_e);
        end
        if (rd_w[sel] != 4'd0) begin
          gap_pending = 1'b1;
          hs_cyc      = cyc;
        end
      end else begin
        stall_pending = 1'b1;
        held          = {rd_w[sel], key_out_w[sel]};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_set(input bit use_zero);
    for (int r = 10; r >= 0; r--)
      exp_q.push_back({4'(r), use_zero ? zero_k[r] : fips_k[r]});
  endtask

  task automatic start_run(input logic [127:0] lk);
    last_key     = lk;
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_cyc    = cyc;
    start_v[sel] = 1'b0;
  endtask

  // Returns at #1 inside the cycle where done is high.
  task automatic wait_done(input bit bp, input bit noise, input int exp_lat);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (done_w[sel]) begin
        start_v[sel] = 1'b0;
        key_ready    = 1'b1;
        check("busy_at_done", 132'(busy_w[sel]), 132'(0));
        if (exp_lat > 0) check("run_latency", 132'(cyc - start_cyc), 132'(exp_lat));
        return;
      end
      if (bp) key_ready = ($urandom_range(0, 9) < 3);
      if (noise) start_v[sel] = ($urandom_range(0, 2) == 0);
    end
    start_v[sel] = 1'b0;
    key_ready    = 1'b1;
    fail_now("wait_done");
  endtask

  task automatic check_done_drop();
    @(posedge clk);
    #1;
    check("done_pulse_width", 132'(done_w[sel]), 132'(0));
    check("busy_after_done", 132'(busy_w[sel]), 132'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_out"}, 132'(key_out_w[sel]), 132'(0));
    check({tag, "_rd"}, 132'(rd_w[sel]), 132'(0));
    check({tag, "_valid"}, 132'(kv_w[sel]), 132'(0));
    check({tag, "_busy"}, 132'(busy_w[sel]), 132'(0));
    check({tag, "_done"}, 132'(done_w[sel]), 132'(0));
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    bit found;
    fips_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_k[0]  = 128'h00000000000000000000000000000000;
    zero_k[1]  = 128'h62636363626363636263636362636363;
    zero_k[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_k[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    zero_k[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    zero_k[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    zero_k[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    zero_k[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    zero_k[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    zero_k[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zero_k[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst_n     = 1'b0;
    start_v   = 2'b00;
    key_ready = 1'b1;
    last_key  = '0;

    for (int s = 0; s < 2; s++) begin
      sel  = s;
      lat  = (s == 0) ? 5 : 2;
      full = (s == 0) ? 51 : 21;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 key, consumer always ready
      push_set(1'b0);
      start_run(fips_k[10]);
      wait_done(1'b0, 1'b0, full);
      check_done_drop();

      // all-zero cipher key
      push_set(1'b1);
      start_run(zero_k[10]);
      wait_done(1'b0, 1'b0, full);
      check_done_drop();

      // random backpressure, ~30% ready duty
      push_set(1'b0);
      start_run(fips_k[10]);
      wait_done(1'b1, 1'b0, 0);
      check_done_drop();

      // stray start pulses while busy, then a start in the done cycle
      push_set(1'b0);
      start_run(fips_k[10]);
      wait_done(1'b0, 1'b1, full);
      push_set(1'b1);
      last_key     = zero_k[10];
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      start_cyc    = cyc;
      start_v[sel] = 1'b0;
      check("start_in_done_cycle", {128'h0, kv_w[sel], rd_w[sel]}, {128'h0, 1'b1, 4'd10});
      wait_done(1'b0, 1'b0, full);
      check_done_drop();

      // reset in the middle of the RD=6 backward step
      push_set(1'b0);
      start_run(fips_k[10]);
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
        @(posedge clk);
        #1;
        if (rd_w[sel] == 4'd6 && !kv_w[sel] && busy_w[sel]) found = 1'b1;
      end
      if (!found) fail_now("reach_rd6_sub");
      if (s == 0) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midsub_reset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_after_reset", 132'(busy_w[sel]), 132'(0));
      push_set(1'b0);
      start_run(fips_k[10]);
      wait_done(1'b0, 1'b0, full);
      check_done_drop();

      check("scoreboard_drained", 132'(exp_q.size()), 132'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative inverse AES-128 key schedule: it runs the `aes_key_xor` step backwards.
- Takes the final round key (round 10) and emits round keys 10, 9, … 0 in descending order over a valid/ready handshake.
- Recomputes each previous round key from the current one, so the decryption datapath needs no stored key expansion.
- Sits between key load and the inverse-cipher round logic.

## Interface
Parameters:
- BYTE_SERIAL, default 1: 1 = one shared S-box, 4 cycles per backward step; 0 = four S-boxes, 1 cycle per step.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  begin a schedule run; sampled only in IDLE.
- last_key  in  128  round-10 key; captured on the accepted start.
- key_out  out  128  current round key, word 0 in [127:96].
- RD  out  4  round number of key_out (10 down to 0).
- key_valid  out  1  key_out/RD valid.
- key_ready  in  1  consumer accepts key_out when high with key_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the round-0 key is accepted.

## Operation
- States: IDLE, EMIT, SUB.
- IDLE:
  - On start: key_reg <= last_key, RD <= 10, go to EMIT.
  - start in any other state is ignored.
- EMIT:
  - key_valid = 1.
  - On key_valid & key_ready with RD == 0: go to IDLE and pulse done.
  - On key_valid & key_ready with RD != 0: go to SUB, byte counter reset to 0.
- SUB: words c0..c3 = key_reg, r = RD.
  - p3 = c3^c2, p2 = c2^c1, p1 = c1^c0.
  - t = SubWord(RotWord(p3)), where RotWord(b0 b1 b2 b3) = b1 b2 b3 b0.
  - p0 = c0 ^ t ^ {Rcon[r], 24'h0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - BYTE_SERIAL=1: 2-bit counter selects byte 0..3 of RotWord(p3) into the single S-box. Bytes 0..2 are registered into t_reg. On count 3, the live S-box output completes t, then key_reg <= {p0,p1,p2,p3}, RD <= RD-1, go to EMIT.
  - BYTE_SERIAL=0: same update in one SUB cycle.
- All arithmetic is GF(2) XOR on 32-bit words; RD never wraps below 0.
- key_ready while key_valid is low is ignored.

## Timing
- Reset values: key_out = 0, RD = 0, key_valid = 0, busy = 0, done = 0, state IDLE, counter 0.
- start accepted at edge S → key_valid = 1 with RD = 10 from S+1.
- Handshake at edge E (RD != 0) → key_valid low from E+1.
  - Next key valid from E+5 (BYTE_SERIAL=1).
  - Next key valid from E+2 (BYTE_SERIAL=0).
- key_out and RD are held stable while key_valid & !key_ready (backpressure of any length).
- Full run with ready tied high, BYTE_SERIAL=1: 11 keys, 51 cycles from start edge to done.
- done is high for exactly the cycle after the RD=0 handshake edge; busy falls in the same cycle.
- start asserted in the same cycle that done is high is accepted (state is IDLE).
- rst_n low at any point, including mid-SUB:
  - immediately clears all outputs to their reset values.
  - partial t_reg is discarded.
  - the block needs a new start.

## Structure
- Package aes_key_pkg:
  - Rcon table as a constant array indexed 1..10.
  - state enum {IDLE, EMIT, SUB}.
  - rot_word function.
  - 32-bit word typedef.
  - Shared with aes_key_xor.
- Sub-module aes_sbox: combinational 8-bit forward S-box, 256-entry case.
  - One instance when BYTE_SERIAL=1; four instances via generate when BYTE_SERIAL=0.
- Expected size: about 200 lines of RTL plus the S-box.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, last_key = d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1:
  - RD 10 → d014f9a8…, RD 9 → ac7766f319fadc2128d12941575c006e, RD 1 → a0fafe1788542cb123a339392a6c7605, RD 0 → 2b7e1516…4f3c.
  - done after 51 cycles.
- All-zero cipher key, last_key = b4ef5bcb3e92e21123e951cf6f8f188e:
  - RD 1 → 62636363626363636263636362636363, RD 0 → all zeros.
- Random backpressure (key_ready 30% duty) on the FIPS key:
  - identical key sequence.
  - key_out/RD never change while key_valid & !key_ready.
- Start pulses during busy: ignored, sequence unaffected. Start in the done cycle: new run begins, RD = 10 on the next cycle.
- rst_n pulsed low mid-SUB at RD=6: outputs zero immediately. A subsequent start with the FIPS last_key gives the full correct sequence.
- Run both BYTE_SERIAL values against the 10000-entry test-vector file (final key → expected key sequence), checking the per-step latencies of 5 and 2 cycles.
